// File: rtl/div_req_pkg.sv
// Shared types for the divider requester: handshake FSM states and timer sizing.
package div_req_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2,
        OUT  = 2'd3
    } req_state_t;

    localparam int DEFAULT_TIMEOUT = 255;

    // Counter must hold values up to the timeout limit.
    function automatic int timer_width(input int limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/div_req_timer.sv
// Clear/enable cycle counter; expire is registered and is high on the LIMIT-th enabled
// cycle after a clear.
module div_req_timer #(
    parameter int LIMIT = 255,
    parameter int W     = 8
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [W-1:0] LAST_BUT_ONE = W'(LIMIT - 2);

    logic [W-1:0] count_reg;
    logic         expire_reg;

    always_ff @(posedge Clock) begin
        if (Reset || clear) begin
            count_reg  <= '0;
            expire_reg <= 1'b0;
        end else if (enable) begin
            count_reg  <= count_reg + 1'b1;
            expire_reg <= (count_reg == LAST_BUT_ONE);
        end
    end

    assign expire = expire_reg;

endmodule

// File: rtl/div_requester.sv
// Initiator side of the divider Req/Done four-phase handshake with valid/ready streams.
// Optional DIVZERO_CHECK_EN: zero divisors are answered locally with an error result.
module div_requester
    import div_req_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InDividend,
    input  logic [WIDTH-1:0] InDivisor,
    output logic             Req,
    input  logic             Done,
    output logic [WIDTH-1:0] Dividend,
    output logic [WIDTH-1:0] Divisor,
    input  logic [WIDTH-1:0] Quotient,
    input  logic [WIDTH-1:0] Remainder,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] OutQuot,
    output logic [WIDTH-1:0] OutRem,
    output logic             OutError
);

    localparam int TIMER_W = timer_width(TIMEOUT_CYCLES);

    req_state_t       state_reg, state_next;
    logic [WIDTH-1:0] dividend_reg, dividend_next;
    logic [WIDTH-1:0] divisor_reg, divisor_next;
    logic [WIDTH-1:0] quot_reg, quot_next;
    logic [WIDTH-1:0] rem_reg, rem_next;
    logic             err_reg, err_next;
    logic             in_ready_reg, req_reg, out_valid_reg;
    logic             expire;

    // Timer restarts on every state change so REQ and REL each get a full budget.
    div_req_timer #(.LIMIT(TIMEOUT_CYCLES), .W(TIMER_W)) timer_inst (
        .Clock  (Clock),
        .Reset  (Reset),
        .clear  (state_next != state_reg),
        .enable ((state_reg == REQ) || (state_reg == REL)),
        .expire (expire)
    );

    always_comb begin
        state_next    = state_reg;
        dividend_next = dividend_reg;
        divisor_next  = divisor_reg;
        quot_next     = quot_reg;
        rem_next      = rem_reg;
        err_next      = err_reg;
        case (state_reg)
            IDLE: begin
                if (InValid) begin
                    dividend_next = InDividend;
                    divisor_next  = InDivisor;
                    quot_next     = '0;
                    rem_next      = '0;
                    err_next      = 1'b0;
                    state_next    = REQ;
`ifdef DIVZERO_CHECK_EN
                    if (InDivisor == '0) begin
                        quot_next  = '1;
                        rem_next   = InDividend;
                        err_next   = 1'b1;
                        state_next = OUT;
                    end
`endif
                end
            end
            REQ: begin
                // Done wins over a timeout landing on the same cycle.
                if (Done) begin
                    quot_next  = Quotient;
                    rem_next   = Remainder;
                    state_next = REL;
                end else if (expire) begin
                    quot_next  = '0;
                    rem_next   = '0;
                    err_next   = 1'b1;
                    state_next = REL;
                end
            end
            REL: begin
                if (!Done) begin
                    state_next = OUT;
                end else if (expire) begin
                    quot_next  = '0;
                    rem_next   = '0;
                    err_next   = 1'b1;
                    state_next = OUT;
                end
            end
            OUT: begin
                if (OutReady) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg     <= IDLE;
            dividend_reg  <= '0;
            divisor_reg   <= '0;
            quot_reg      <= '0;
            rem_reg       <= '0;
            err_reg       <= 1'b0;
            in_ready_reg  <= 1'b1;
            req_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            dividend_reg  <= dividend_next;
            divisor_reg   <= divisor_next;
            quot_reg      <= quot_next;
            rem_reg       <= rem_next;
            err_reg       <= err_next;
            in_ready_reg  <= (state_next == IDLE);
            req_reg       <= (state_next == REQ);
            out_valid_reg <= (state_next == OUT);
        end
    end

    assign InReady  = in_ready_reg;
    assign Req      = req_reg;
    assign OutValid = out_valid_reg;
    assign Dividend = dividend_reg;
    assign Divisor  = divisor_reg;
    assign OutQuot  = quot_reg;
    assign OutRem   = rem_reg;
    assign OutError = err_reg;

endmodule
